sub_bytes_iter: RTL and testbench

Iterative, parametrised AES SubBytes engine that replaces the purely combinational 16-S-box SubBytes stage where area matters. It accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through a shared S-box bank. It returns the result over a second valid/ready handshake. It sits between AddRoundKey and ShiftRows in the round datapath and optionally performs InvSubBytes for decryption.

---
 rtl/aes_pkg.sv | 81 ++++++++
 rtl/sbox_lane.sv | 26 ++
 rtl/sub_bytes_iter.sv | 116 +++++++++++
 tb/tb_sub_bytes_iter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state type, SubBytes FSM states and the forward and inverse S-box tables.
// Each pair of table rows matches one row of the usual 16x16 S-box listing.
package aes_pkg;

  localparam int unsigned NB_BYTES = 16;

  typedef logic [0:127] aes_state_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} sb_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lane.sv
// One S-box lane: combinational byte substitution by table lookup.
// Macro SUBBYTES_INV_EN adds the inverse table; without it inv_i is ignored.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       inv_i,
  output logic [7:0] byte_o
);

`ifdef SUBBYTES_INV_EN
  // Forward or inverse lookup selected per transaction.
  always_comb begin
    byte_o = inv_i ? INV_SBOX[byte_i] : SBOX[byte_i];
  end
`else
  logic unused_inv;
  assign unused_inv = inv_i;

  // Forward lookup only.
  always_comb begin
    byte_o = SBOX[byte_i];
  end
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES bytes per cycle through a shared S-box bank, 16/LANES cycles
// per state, valid/ready on both sides. Macro SUBBYTES_INV_EN enables InvSubBytes via in_inv.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_inv,
  input  logic [0:127]   in_state,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [0:127]   out_state,
  output logic           busy
);

  localparam int unsigned N  = NB_BYTES / LANES;
  localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gen_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  sb_state_e       state_q, state_d;
  aes_state_t      work_q, work_d;
  logic [GW-1:0]   g_q, g_d;
  logic            mode_q, mode_d;
  logic            accept;
  int unsigned     base;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];

  // Handshake and status decode; in_ready never depends on in_valid.
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_state = work_q;
  assign base      = 32'(g_q) * LANES;

`ifndef SUBBYTES_INV_EN
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  // Select the current group of bytes for the lane bank.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_in[l] = work_q[8*(base + l) +: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : gen_lane
    sbox_lane u_lane (
      .byte_i (lane_in[l]),
      .inv_i  (mode_q),
      .byte_o (lane_out[l])
    );
  end

  // Next-state logic: load on accept, substitute one group per RUN cycle.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    g_d     = g_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          work_d  = in_state;
          g_d     = '0;
`ifdef SUBBYTES_INV_EN
          mode_d  = in_inv;
`else
          mode_d  = 1'b0;
`endif
          state_d = StRun;
        end else if ((state_q == StDone) && out_ready) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          work_d[8*(base + l) +: 8] = lane_out[l];
        end
        // Wrap g on the last group so it never indexes past the state.
        if (g_q == GW'(N - 1)) begin
          g_d     = '0;
          state_d = StDone;
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      g_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      g_q     <= g_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter: one instance per legal LANES value (1,2,4,8,16),
// reference S-box derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_iter;

  localparam int NL = 5;
`ifdef SUBBYTES_INV_EN
  localparam bit InvEn = 1'b1;
`else
  localparam bit InvEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid  [NL];
  logic         in_inv    [NL];
  logic         out_ready [NL];
  logic [0:127] in_state  [NL];
  logic         in_ready  [NL];
  logic         out_valid [NL];
  logic         busy      [NL];
  logic [0:127] out_state [NL];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_sbox [256];
  logic [7:0] m_inv  [256];

  for (genvar k = 0; k < NL; k++) begin : g_dut
    sub_bytes_iter #(.LANES(1 << k)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_inv    (in_inv[k]),
      .in_state  (in_state[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_state (out_state[k]),
      .busy      (busy[k])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_model();
    logic [7:0] r;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      r = 8'h01;
      if (x == 0) r = 8'h00;
      else for (int e = 0; e < 254; e++) r = gmul(r, 8'(x));
      s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
      m_sbox[x] = s;
      m_inv[s]  = 8'(x);
    end
  endtask

  function automatic logic [0:127] model_sub(input logic [0:127] d, input logic inv);
    logic [0:127] r;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = (inv && InvEn) ? m_inv[d[8*i +: 8]] : m_sbox[d[8*i +: 8]];
    end
    return r;
  endfunction

  function automatic logic [0:127] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one state to instance k, wait for out_valid; lat counts edges after acceptance.
  task automatic run_txn(input int k, input logic [0:127] d, input logic inv,
                         output logic [0:127] res, output int lat);
    int w = 0;
    @(negedge clk);
    in_state[k] = d;
    in_inv[k]   = inv;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout lane_cfg=%0d: in_ready stayed 0, required 1", k);
    end
    @(posedge clk);
    #1 in_valid[k] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid[k] && lat < 100);
    res = out_state[k];
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < NL; k++) begin
      n_cmp += 4;
      if (out_valid[k] !== 1'b0) begin
        n_bad++; $display("FAIL reset_out_valid k=%0d: got %b required 0", k, out_valid[k]);
      end
      if (busy[k] !== 1'b0) begin
        n_bad++; $display("FAIL reset_busy k=%0d: got %b required 0", k, busy[k]);
      end
      if (in_ready[k] !== 1'b1) begin
        n_bad++; $display("FAIL reset_in_ready k=%0d: got %b required 1", k, in_ready[k]);
      end
      if (out_state[k] !== 128'h0) begin
        n_bad++; $display("FAIL reset_out_state k=%0d: got %h required 0", k, out_state[k]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    logic [0:127] res;
    int lat;
    run_txn(2, 128'h0, 1'b0, res, lat);
    n_cmp += 2;
    if (res !== {16{8'h63}}) begin
      n_bad++; $display("FAIL zero_state: got %h required %h", res, {16{8'h63}});
    end
    if (lat !== 4) begin
      n_bad++; $display("FAIL zero_latency: got %0d required 4", lat);
    end
  endtask

  task automatic test_fips();
    logic [0:127] res;
    int lat;
    for (int k = 0; k < NL; k++) begin
      run_txn(k, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, res, lat);
      n_cmp += 2;
      if (res !== 128'hd42711aee0bf98f1b8b45de51e415230) begin
        n_bad++; $display("FAIL fips_state lanes=%0d: got %h required %h", 1 << k, res,
                          128'hd42711aee0bf98f1b8b45de51e415230);
      end
      if (lat !== (16 >> k)) begin
        n_bad++; $display("FAIL fips_latency lanes=%0d: got %0d required %0d", 1 << k, lat, 16 >> k);
      end
    end
  endtask

  task automatic test_inverse();
    logic [0:127] res;
    logic [0:127] d;
    logic [0:127] exp;
    int lat;
    d   = 128'hd42711aee0bf98f1b8b45de51e415230;
    exp = InvEn ? 128'h193de3bea0f4e22b9ac68d2ae9f84808 : model_sub(d, 1'b0);
    run_txn(2, d, 1'b1, res, lat);
    n_cmp++;
    if (res !== exp) begin
      n_bad++; $display("FAIL inverse_state: got %h required %h", res, exp);
    end
  endtask

  task automatic test_single_byte();
    logic [0:127] res;
    int lat;
    run_txn(0, {4{32'hdbf201c6}}, 1'b0, res, lat);
    n_cmp += 2;
    if (res !== {4{32'hb9897cb4}}) begin
      n_bad++; $display("FAIL single_byte_state: got %h required %h", res, {4{32'hb9897cb4}});
    end
    if (lat !== 16) begin
      n_bad++; $display("FAIL single_byte_latency: got %0d required 16", lat);
    end
  endtask

  task automatic test_random();
    logic [0:127] res;
    logic [0:127] d;
    logic inv;
    int k;
    int lat;
    for (int i = 0; i < 24; i++) begin
      k   = int'($urandom_range(0, NL - 1));
      d   = rand_state();
      inv = 1'($urandom_range(0, 1));
      run_txn(k, d, inv, res, lat);
      n_cmp += 2;
      if (res !== model_sub(d, inv)) begin
        n_bad++; $display("FAIL random_state lanes=%0d inv=%b: got %h required %h",
                          1 << k, inv, res, model_sub(d, inv));
      end
      if (lat !== (16 >> k)) begin
        n_bad++; $display("FAIL random_latency lanes=%0d: got %0d required %0d", 1 << k, lat, 16 >> k);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [0:127] res;
    logic [0:127] d;
    int lat;
    d = rand_state();
    out_ready[2] = 1'b0;
    run_txn(2, d, 1'b0, res, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp += 3;
      if (out_state[2] !== model_sub(d, 1'b0)) begin
        n_bad++; $display("FAIL stall_state c=%0d: got %h required %h", c, out_state[2],
                          model_sub(d, 1'b0));
      end
      if (out_valid[2] !== 1'b1) begin
        n_bad++; $display("FAIL stall_out_valid c=%0d: got %b required 1", c, out_valid[2]);
      end
      if (in_ready[2] !== 1'b0) begin
        n_bad++; $display("FAIL stall_in_ready c=%0d: got %b required 0", c, in_ready[2]);
      end
    end
    in_state[2]  = 128'h0;
    in_inv[2]    = 1'b0;
    in_valid[2]  = 1'b1;
    out_ready[2] = 1'b1;
    #1;
    n_cmp++;
    if (in_ready[2] !== 1'b1) begin
      n_bad++; $display("FAIL b2b_in_ready: got %b required 1", in_ready[2]);
    end
    @(posedge clk);
    #1 in_valid[2] = 1'b0;
    n_cmp++;
    if (busy[2] !== 1'b1 || out_valid[2] !== 1'b0) begin
      n_bad++; $display("FAIL b2b_run: got busy=%b out_valid=%b required busy=1 out_valid=0",
                        busy[2], out_valid[2]);
    end
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid[2] && lat < 100);
    n_cmp += 2;
    if (out_state[2] !== {16{8'h63}}) begin
      n_bad++; $display("FAIL b2b_state: got %h required %h", out_state[2], {16{8'h63}});
    end
    if (lat !== 4) begin
      n_bad++; $display("FAIL b2b_latency: got %0d required 4", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:127] d   [3];
    logic [0:127] res [3];
    int acc [3];
    int oc  [3];
    int ia = 0;
    int ir = 0;
    int c  = 0;
    logic pre;
    for (int i = 0; i < 3; i++) d[i] = rand_state();
    while (ir < 3 && c < 60) begin
      @(negedge clk);
      in_valid[2] = (ia < 3);
      in_inv[2]   = 1'b0;
      if (ia < 3) in_state[2] = d[ia];
      pre = in_ready[2] && in_valid[2];
      @(posedge clk);
      if (pre) begin
        acc[ia] = c;
        ia++;
      end
      #1;
      if (out_valid[2] && ir < 3) begin
        res[ir] = out_state[2];
        oc[ir]  = c;
        ir++;
      end
      c++;
    end
    in_valid[2] = 1'b0;
    n_cmp++;
    if (ir !== 3 || ia !== 3) begin
      n_bad++; $display("FAIL b2b_stream_count: got accepted=%0d results=%0d required 3/3", ia, ir);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp += 2;
        if (res[i] !== model_sub(d[i], 1'b0)) begin
          n_bad++; $display("FAIL b2b_stream_state i=%0d: got %h required %h", i, res[i],
                            model_sub(d[i], 1'b0));
        end
        if (oc[i] - acc[i] !== 4) begin
          n_bad++; $display("FAIL b2b_stream_latency i=%0d: got %0d required 4", i, oc[i] - acc[i]);
        end
      end
      n_cmp += 2;
      if (acc[1] - acc[0] !== 5) begin
        n_bad++; $display("FAIL b2b_throughput_0: got %0d required 5", acc[1] - acc[0]);
      end
      if (acc[2] - acc[1] !== 5) begin
        n_bad++; $display("FAIL b2b_throughput_1: got %0d required 5", acc[2] - acc[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [0:127] res;
    logic [0:127] d;
    int lat;
    @(negedge clk);
    in_state[2] = rand_state();
    in_inv[2]   = 1'b0;
    in_valid[2] = 1'b1;
    @(posedge clk);
    #1 in_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy[2] !== 1'b1 || in_ready[2] !== 1'b0) begin
      n_bad++; $display("FAIL mid_run_status: got busy=%b in_ready=%b required busy=1 in_ready=0",
                        busy[2], in_ready[2]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (out_valid[2] !== 1'b0) begin
      n_bad++; $display("FAIL mid_run_rst_out_valid: got %b required 0", out_valid[2]);
    end
    if (busy[2] !== 1'b0) begin
      n_bad++; $display("FAIL mid_run_rst_busy: got %b required 0", busy[2]);
    end
    if (in_ready[2] !== 1'b1) begin
      n_bad++; $display("FAIL mid_run_rst_in_ready: got %b required 1", in_ready[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d = rand_state();
    run_txn(2, d, 1'b0, res, lat);
    n_cmp += 2;
    if (res !== model_sub(d, 1'b0)) begin
      n_bad++; $display("FAIL post_reset_state: got %h required %h", res, model_sub(d, 1'b0));
    end
    if (lat !== 4) begin
      n_bad++; $display("FAIL post_reset_latency: got %0d required 4", lat);
    end
    // Reset while a result is stalled in DONE.
    out_ready[1] = 1'b0;
    run_txn(1, rand_state(), 1'b0, res, lat);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
      n_bad++; $display("FAIL mid_done_rst: got out_valid=%b busy=%b required 0/0",
                        out_valid[1], busy[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready[1] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NL; k++) begin
      in_valid[k]  = 1'b0;
      in_inv[k]    = 1'b0;
      out_ready[k] = 1'b1;
      in_state[k]  = '0;
    end
    build_model();
    test_reset();
    test_zero();
    test_fips();
    test_inverse();
    test_single_byte();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
